renkon_loader: RTL and testbench
================================

Name: renkon_loader

Overview:
- Upstream feeder for renkon_top. Takes a host word stream (valid/ready) and writes it into the image memory port (img_we/input_addr/write_img) or the per-core network memory port (net_we/net_addr/write_net).
- Produces the exact layout the conv core expects: per-core weight blocks with bias appended, and zero-filled blocks for unused cores in the last output group.
- Replaces host-side word-by-word poking. Runs to completion before renkon_top receives req.

Parameters:
- DWIDTH, 16, data word width.
- IMGSIZE, 12, image memory address width.
- NETSIZE, 14, network memory address width.
- CORE, 8, number of PE cores.
- CORELOG, 3, log2(CORE).
- LWIDTH, 10, width of layer-size fields.

Ports:
- clk, in, 1, clock.
- xrst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle load request; sampled only in IDLE.
- mode, in, 1, 0 = image load, 1 = network load; latched on start.
- total_out, in, LWIDTH, output channel count; latched on start.
- total_in, in, LWIDTH, input channel count; latched on start.
- img_size, in, LWIDTH, image edge length; latched on start.
- fil_size, in, LWIDTH, filter edge length; latched on start.
- base_addr, in, NETSIZE, start address (low IMGSIZE bits used in image mode).
- s_valid, in, 1, host word valid.
- s_data, in, DWIDTH signed, host word.
- s_ready, out, 1, block accepts the word this cycle.
- img_we, out, 1, image memory write enable.
- img_addr, out, IMGSIZE, image memory address.
- write_img, out, DWIDTH signed, image write data.
- net_we, out, CORELOG+1, 0 = idle, n+1 = write core n.
- net_addr, out, NETSIZE, network memory address.
- write_net, out, DWIDTH signed, network write data.
- busy, out, 1, high from SETUP through DONE.
- done, out, 1, one-cycle completion pulse.

Behaviour:
- Reset (async, xrst=0): state IDLE. All outputs 0, including s_ready, busy, done, all we, addr and data.
- Reset mid-operation: the load is abandoned, no partial pulse is emitted, and the block returns to IDLE.
- States: IDLE, SETUP, LOAD, PAD, DONE.
- IDLE: on start=1, latch all inputs and go to SETUP.
- SETUP (1 cycle) computes sizes:
  - image mode: N = total_in*img_size*img_size.
  - network mode: B = total_in*fil_size*fil_size + 1; G = ceil(total_out/CORE).
  - Products are computed at 2*LWIDTH+LWIDTH width, then truncated to the address width.
  - If N=0 (image mode) or total_out=0 or total_in=0 (network mode), go directly to DONE with no writes. Otherwise go to LOAD.
- LOAD:
  - s_ready=1. Each handshake (s_valid & s_ready) produces exactly one registered write on the next cycle.
  - Image mode: img_we=1, img_addr=base+i (mod 2^IMGSIZE), write_img=s_data, for i=0..N-1.
  - Network mode, counters g (group), dn (core), k (0..B-1):
    - net_we=dn+1, net_addr=base+g*B+k, write_net=s_data.
    - Word k=B-1 is the bias.
    - k wraps to 0 and increments dn; dn wraps at CORE and increments g.
  - Stream order expected from the host: channel 0 weights (m, i, j order) then bias, then channel 1, and so on.
  - If a word is not accepted (s_valid=0), nothing is written that cycle and all we are 0.
  - Leaving LOAD:
    - image mode, after the last word: go to DONE.
    - network mode, when g*CORE+dn reaches total_out: if dn=0, go to DONE; otherwise go to PAD.
- PAD:
  - s_ready=0. Write B zero words per remaining core (dn..CORE-1) of the last group, one per cycle, at the same addresses as LOAD would use.
  - After core CORE-1, go to DONE.
- DONE: done=1 for one cycle, busy=0 on the following cycle, then IDLE.
- start while busy is ignored.
- s_ready is combinational from state only; it never depends on s_valid.
- When a write is not issued, we outputs are 0; addr and data hold their last value.

Test Plan:
- Image mode, total_in=16, img_size=12, base=0, s_valid always 1 -> 2304 writes, img_addr 0..2303 with data matching the stream; done 1 cycle after the last img_we; s_ready low thereafter.
- Network mode, total_out=32, total_in=16, fil_size=5, CORE=8 -> B=401, G=4. Word 401 goes to core 1 (net_we=2) at addr 0. Word 3208 goes to core 0 at addr 401. No PAD; 12832 writes total.
- Network mode, total_out=10, total_in=1, fil_size=3 -> B=10. Cores 0,1 of group 1 are loaded at addr 10..19. Cores 2..7 receive 10 zero writes each with s_ready=0; 60 PAD cycles, then done.
- Randomised s_valid gaps (about 50% duty) on the image case -> identical memory contents; no write on idle cycles.
- xrst pulled low mid-LOAD, then start re-issued -> all outputs 0 during reset; the full load completes correctly from base.
- total_in=0 -> done 2 cycles after start, zero writes; a second start during busy has no effect.

Source files
------------

// File: rtl/renkon_loader_if.sv
// Host word-stream interface for renkon_loader.
// Ports:
//   s_valid - host word valid (master -> slave)
//   s_data  - host word, signed (master -> slave)
//   s_ready - loader accepts the word this cycle (slave -> master)
interface renkon_loader_if #(
  parameter int DWIDTH = 16
) ();
  logic                     s_valid;
  logic signed [DWIDTH-1:0] s_data;
  logic                     s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/renkon_loader.sv
// renkon_loader: streams host words into the renkon_top image memory or the
// per-core network memories, producing the layout the conv core expects
// (per-core weight blocks with trailing bias, zero blocks for unused cores of
// the last output group).
// Ports:
//   clk, xrst            - clock, asynchronous active-low reset
//   start, mode          - load request (IDLE only); 0 = image, 1 = network
//   total_out, total_in,
//   img_size, fil_size,
//   base_addr            - layer geometry and start address, latched on start
//   host                 - host word stream (slave side)
//   img_we/img_addr/write_img  - image memory write port
//   net_we/net_addr/write_net  - network memory write port (net_we = core+1)
//   busy, done           - activity flag and one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// SETUP | compute block size from latched geometry
// LOAD  | accept host words, one write per handshake
// PAD   | zero-fill remaining cores of the last output group
// DONE  | completion; done pulse follows
module renkon_loader #(
  parameter int DWIDTH  = 16,
  parameter int IMGSIZE = 12,
  parameter int NETSIZE = 14,
  parameter int CORE    = 8,
  parameter int CORELOG = 3,
  parameter int LWIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [LWIDTH-1:0]         total_out,
  input  logic [LWIDTH-1:0]         total_in,
  input  logic [LWIDTH-1:0]         img_size,
  input  logic [LWIDTH-1:0]         fil_size,
  input  logic [NETSIZE-1:0]        base_addr,
  renkon_loader_if.slave            host,
  output logic                      img_we,
  output logic [IMGSIZE-1:0]        img_addr,
  output logic signed [DWIDTH-1:0]  write_img,
  output logic [CORELOG:0]          net_we,
  output logic [NETSIZE-1:0]        net_addr,
  output logic signed [DWIDTH-1:0]  write_net,
  output logic                      busy,
  output logic                      done
);

  localparam int PW = 3 * LWIDTH;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_PAD, S_DONE} state_t;

  state_t state, state_nx;

  logic                mode_r;
  logic [LWIDTH-1:0]   tot_out_r, tot_in_r, img_size_r, fil_size_r;
  logic [NETSIZE-1:0]  base_r;
  logic [NETSIZE-1:0]  size_r;     // N (image) or B (network)
  logic [NETSIZE-1:0]  cnt;        // word index i (image) or k (network)
  logic [CORELOG-1:0]  dn;
  logic [NETSIZE-1:0]  row_base;   // base + g*B
  logic [LWIDTH-1:0]   ch;         // cores fully loaded so far

  logic [IMGSIZE-1:0]  n_img;
  logic [NETSIZE-1:0]  b_net;
  logic                setup_zero;
  logic                fire, last_k, core_last;
  logic [LWIDTH-1:0]   ch_inc;
  logic [CORELOG:0]    net_sel;
  logic [NETSIZE-1:0]  cnt_adv, row_adv;
  logic [CORELOG-1:0]  dn_adv;

  // Full-width products, then truncated to the address width.
  assign n_img = IMGSIZE'(PW'(tot_in_r) * PW'(img_size_r) * PW'(img_size_r));
  assign b_net = NETSIZE'(PW'(tot_in_r) * PW'(fil_size_r) * PW'(fil_size_r))
                 + NETSIZE'(1);

  assign setup_zero = mode_r ? ((tot_out_r == '0) || (tot_in_r == '0))
                             : (n_img == '0);

  assign host.s_ready = (state == S_LOAD);
  assign fire         = host.s_ready && host.s_valid;
  assign last_k       = (cnt == size_r - NETSIZE'(1));
  assign core_last    = (dn == CORELOG'(CORE - 1));
  assign ch_inc       = ch + LWIDTH'(1);
  assign net_sel      = {1'b0, dn} + (CORELOG+1)'(1);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_adv  = last_k ? '0 : cnt + NETSIZE'(1);
    dn_adv   = dn;
    row_adv  = row_base;
    if (last_k) begin
      if (core_last) begin
        dn_adv  = '0;
        row_adv = row_base + size_r;
      end else begin
        dn_adv  = dn + CORELOG'(1);
      end
    end

    case (state)
      S_IDLE:  if (start) state_nx = S_SETUP;
      S_SETUP: state_nx = setup_zero ? S_DONE : S_LOAD;
      S_LOAD: begin
        if (fire) begin
          if (!mode_r) begin
            if (last_k) state_nx = S_DONE;
          end else if (last_k && (ch_inc == tot_out_r)) begin
            // Ending exactly on a group boundary needs no padding.
            state_nx = core_last ? S_DONE : S_PAD;
          end
        end
      end
      S_PAD:   if (last_k && core_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      mode_r     <= 1'b0;
      tot_out_r  <= '0;
      tot_in_r   <= '0;
      img_size_r <= '0;
      fil_size_r <= '0;
      base_r     <= '0;
      size_r     <= '0;
      cnt        <= '0;
      dn         <= '0;
      row_base   <= '0;
      ch         <= '0;
      img_we     <= 1'b0;
      img_addr   <= '0;
      write_img  <= '0;
      net_we     <= '0;
      net_addr   <= '0;
      write_net  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      img_we <= 1'b0;
      net_we <= '0;
      // Outputs trail the state by one cycle, so busy stays up through the
      // done pulse and drops on the cycle after it.
      busy   <= (state_nx != S_IDLE) || (state == S_DONE);
      done   <= (state == S_DONE);

      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r     <= mode;
            tot_out_r  <= total_out;
            tot_in_r   <= total_in;
            img_size_r <= img_size;
            fil_size_r <= fil_size;
            base_r     <= base_addr;
          end
        end
        S_SETUP: begin
          size_r   <= mode_r ? b_net : NETSIZE'(n_img);
          cnt      <= '0;
          dn       <= '0;
          ch       <= '0;
          row_base <= base_r;
        end
        S_LOAD: begin
          if (fire) begin
            if (!mode_r) begin
              img_we    <= 1'b1;
              img_addr  <= base_r[IMGSIZE-1:0] + cnt[IMGSIZE-1:0];
              write_img <= host.s_data;
              cnt       <= cnt + NETSIZE'(1);
            end else begin
              net_we    <= net_sel;
              net_addr  <= row_base + cnt;
              write_net <= host.s_data;
              cnt       <= cnt_adv;
              dn        <= dn_adv;
              row_base  <= row_adv;
              if (last_k) ch <= ch_inc;
            end
          end
        end
        S_PAD: begin
          net_we    <= net_sel;
          net_addr  <= row_base + cnt;
          write_net <= '0;
          cnt       <= cnt_adv;
          dn        <= dn_adv;
          row_base  <= row_adv;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_renkon_loader.sv
module tb_renkon_loader;
  localparam int DW = 16, IS = 12, NS = 14, CORE = 8, CL = 3, LW = 10;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  logic                  start = 1'b0, mode = 1'b0;
  logic [LW-1:0]         total_out = '0, total_in = '0, img_size = '0, fil_size = '0;
  logic [NS-1:0]         base_addr = '0;
  logic                  img_we;
  logic [IS-1:0]         img_addr;
  logic signed [DW-1:0]  write_img;
  logic [CL:0]           net_we;
  logic [NS-1:0]         net_addr;
  logic signed [DW-1:0]  write_net;
  logic                  busy, done;

  renkon_loader_if #(.DWIDTH(DW)) host ();

  renkon_loader #(.DWIDTH(DW), .IMGSIZE(IS), .NETSIZE(NS), .CORE(CORE),
                  .CORELOG(CL), .LWIDTH(LW)) dut (
    .clk(clk), .xrst(xrst), .start(start), .mode(mode),
    .total_out(total_out), .total_in(total_in), .img_size(img_size),
    .fil_size(fil_size), .base_addr(base_addr), .host(host),
    .img_we(img_we), .img_addr(img_addr), .write_img(write_img),
    .net_we(net_we), .net_addr(net_addr), .write_net(write_net),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic          net;
    logic          pad;
    logic [CL:0]   we;
    logic [NS-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] word_data(input int w);
    return DW'(w * 40503 + 4660);
  endfunction

  function automatic exp_t exp_net(input int w, input int b, input int base,
                                   input logic [DW-1:0] d, input logic pad);
    exp_t e;
    int core, k, g, dn;
    core = w / b;
    k    = w % b;
    g    = core / CORE;
    dn   = core % CORE;
    e.net  = 1'b1;
    e.pad  = pad;
    e.we   = (CL+1)'(dn + 1);
    e.addr = NS'(base + g * b + k);
    e.data = d;
    return e;
  endfunction

  function automatic exp_t exp_img(input int w, input int base);
    exp_t e;
    e.net  = 1'b0;
    e.pad  = 1'b0;
    e.we   = (CL+1)'(1);
    e.addr = NS'((base + w) % 4096);
    e.data = word_data(w);
    return e;
  endfunction

  task automatic do_start(input logic m, input int tout, input int tin,
                          input int isz, input int fsz, input int base);
    @(negedge clk);
    mode      = m;
    total_out = LW'(tout);
    total_in  = LW'(tin);
    img_size  = LW'(isz);
    fil_size  = LW'(fsz);
    base_addr = NS'(base);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Drives the host stream and scoreboards every write until done or budget.
  task automatic run_load(input logic net, input int nwords, input int b,
                          input int tout, input int base, input int vpct,
                          input int budget, input bit need_done,
                          output int wr_cnt, output int last_we,
                          output int done_at, output int pad_seen);
    int   w;
    bit   fin;
    int   ngroups;
    exp_t e;
    w = 0; fin = 0;
    wr_cnt = 0; last_we = -1; done_at = -1; pad_seen = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      if (img_we || net_we != '0) begin
        wr_cnt++;
        last_we = c;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got img_we=%0b net_we=%0d img_addr=%0d net_addr=%0d, required no write",
                   img_we, net_we, img_addr, net_addr);
        end else begin
          e = sb.pop_front();
          if (e.pad) pad_seen++;
          if (e.net) begin
            if (img_we !== 1'b0 || net_we !== e.we || net_addr !== e.addr ||
                write_net !== e.data || (e.pad && host.s_ready !== 1'b0)) begin
              n_fail++;
              $display("FAIL net_write: got we=%0d addr=%0d data=%h img_we=%0b ready=%0b, required we=%0d addr=%0d data=%h pad=%0b",
                       net_we, net_addr, write_net, img_we, host.s_ready, e.we, e.addr, e.data, e.pad);
            end
          end else begin
            if (net_we !== '0 || img_we !== 1'b1 || img_addr !== e.addr[IS-1:0] ||
                write_img !== e.data) begin
              n_fail++;
              $display("FAIL img_write: got addr=%0d data=%h net_we=%0d, required addr=%0d data=%h",
                       img_addr, write_img, net_we, e.addr[IS-1:0], e.data);
            end
          end
        end
      end
      if (done === 1'b1) begin
        done_at = c;
        fin = 1;
      end else begin
        host.s_valid = (w < nwords) && ($urandom_range(99) < vpct);
        host.s_data  = word_data(w);
        if (host.s_valid && host.s_ready) begin
          sb.push_back(net ? exp_net(w, b, base, word_data(w), 1'b0) : exp_img(w, base));
          w++;
          if (net && w == nwords) begin
            ngroups = (tout + CORE - 1) / CORE;
            for (int core = tout; core < ngroups * CORE; core++)
              for (int k = 0; k < b; k++)
                sb.push_back(exp_net(core * b + k, b, base, '0, 1'b1));
          end
        end
      end
    end
    host.s_valid = 1'b0;
    if (need_done && !fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got no done in %0d cycles, required done", budget);
    end
  endtask

  task automatic check_finish(input string name, input int wr_cnt, input int want,
                              input int last_we, input int done_at);
    n_checks++;
    if (wr_cnt != want) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, wr_cnt, want);
    end
    n_checks++;
    if (done_at < 0 || done_at != last_we + 1) begin
      n_fail++;
      $display("FAIL %s_done_timing: got done at %0d, required %0d", name, done_at, last_we + 1);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: got %0d pending writes, required 0", name, sb.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (host.s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl: got ready=%0b busy=%0b done=%0b, required 0 0 0", name, host.s_ready, busy, done);
    end
    n_checks++;
    if (img_we !== 1'b0 || net_we !== '0) begin
      n_fail++;
      $display("FAIL %s_we: got img_we=%0b net_we=%0d, required 0", name, img_we, net_we);
    end
    n_checks++;
    if (img_addr !== '0 || net_addr !== '0 || write_img !== '0 || write_net !== '0) begin
      n_fail++;
      $display("FAIL %s_bus: got img_addr=%0d net_addr=%0d write_img=%h write_net=%h, required all 0",
               name, img_addr, net_addr, write_img, write_net);
    end
  endtask

  task automatic test_reset();
    host.s_valid = 1'b0;
    host.s_data  = '0;
    xrst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    xrst = 1'b1;
  endtask

  task automatic test_image();
    int wr, lw, da, ps;
    do_start(1'b0, 1, 16, 12, 1, 0);
    run_load(1'b0, 2304, 0, 0, 0, 100, 2400, 1'b1, wr, lw, da, ps);
    check_finish("image", wr, 2304, lw, da);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL image_busy_at_done: got %0b, required 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || host.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL image_after_done: got done=%0b busy=%0b ready=%0b, required 0 0 0", done, busy, host.s_ready);
    end
  endtask

  task automatic test_network_full();
    int wr, lw, da, ps;
    do_start(1'b1, 32, 16, 1, 5, 0);
    run_load(1'b1, 12832, 401, 32, 0, 100, 13000, 1'b1, wr, lw, da, ps);
    check_finish("net_full", wr, 12832, lw, da);
    n_checks++;
    if (ps != 0) begin
      n_fail++;
      $display("FAIL net_full_pad: got %0d pad writes, required 0", ps);
    end
  endtask

  task automatic test_network_pad();
    int wr, lw, da, ps;
    do_start(1'b1, 10, 1, 1, 3, 0);
    run_load(1'b1, 100, 10, 10, 0, 100, 400, 1'b1, wr, lw, da, ps);
    check_finish("net_pad", wr, 160, lw, da);
    n_checks++;
    if (ps != 60) begin
      n_fail++;
      $display("FAIL net_pad_zero: got %0d pad writes, required 60", ps);
    end
  endtask

  task automatic test_gaps();
    int wr, lw, da, ps;
    do_start(1'b0, 1, 16, 12, 1, 0);
    run_load(1'b0, 2304, 0, 0, 0, 50, 7000, 1'b1, wr, lw, da, ps);
    check_finish("gaps", wr, 2304, lw, da);
  endtask

  task automatic test_reset_mid();
    int wr, lw, da, ps;
    do_start(1'b0, 1, 16, 12, 1, 0);
    run_load(1'b0, 2304, 0, 0, 0, 100, 100, 1'b0, wr, lw, da, ps);
    @(negedge clk);
    xrst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    do_start(1'b0, 1, 16, 12, 1, 2000);
    run_load(1'b0, 2304, 0, 0, 2000, 100, 2400, 1'b1, wr, lw, da, ps);
    check_finish("reload", wr, 2304, lw, da);
  endtask

  task automatic test_zero_in();
    int writes, done_at, done_cnt;
    logic busy_mid;
    writes = 0; done_at = -1; done_cnt = 0; busy_mid = 1'b0;
    @(negedge clk);
    mode = 1'b1; total_out = LW'(8); total_in = '0; fil_size = LW'(3); base_addr = '0;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      // start is sampled at the first edge; done rises two edges later.
      if (c == 1) start = 1'b0;
      if (c == 2) begin
        busy_mid = busy;
        start = 1'b1;
      end
      if (c == 3) start = 1'b0;
      if (img_we || net_we != '0) writes++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    n_checks++;
    if (done_at != 3) begin
      n_fail++;
      $display("FAIL zero_done_timing: got done at %0d, required 3", done_at);
    end
    n_checks++;
    if (writes != 0) begin
      n_fail++;
      $display("FAIL zero_writes: got %0d, required 0", writes);
    end
    n_checks++;
    if (busy_mid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_busy: got %0b, required 1", busy_mid);
    end
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_restart_ignored: got done_pulses=%0d busy=%0b, required 1 0", done_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_image();
    test_network_full();
    test_network_pad();
    test_gaps();
    test_reset_mid();
    test_zero_in();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end

endmodule
